// File: rtl/line_clear_scheduler.sv
// Post-landing sequencer for the 10x10 game table: collapses full rows, inserts queued
// garbage rows, commits the table with one write strobe and emits attack pulses.
module line_clear_scheduler (
  input  logic         clk_40M,
  input  logic         rst,
  input  logic         start,
  input  logic [99:0]  table_in,
  input  logic         add_line,
  output logic         busy,
  output logic [99:0]  table_out,
  output logic         table_we,
  output logic         send_line,
  output logic         done,
  output logic [3:0]   pending,
  output logic [7:0]   lines_total,
  output logic         game_over
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    GARBAGE = 3'd2,
    COMMIT  = 3'd3,
    SEND    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [99:0] work_r, work_s;
  logic [3:0]  row_ptr_r, row_ptr_s;
  logic [3:0]  clr_cnt_r, clr_cnt_s;
  logic [2:0]  send_cnt_r, send_cnt_s;
  logic        send_ph_r, send_ph_s;
  logic [3:0]  hole_r;
  logic [9:0]  full_s;
  logic        line_clr_s, pend_dec_s, overflow_s;

  // Rows 1..p drop by one row, row 0 is refilled with zeros, rows below p untouched.
  function automatic logic [99:0] collapse_rows(input logic [99:0] t, input logic [3:0] p);
    logic [99:0] res;
    res       = t;
    res[9:0]  = 10'd0;
    for (int r = 1; r < 10; r++) begin
      if (4'(r) <= p) res[r*10 +: 10] = t[(r-1)*10 +: 10];
      else            res[r*10 +: 10] = t[r*10 +: 10];
    end
    return res;
  endfunction

  function automatic logic [2:0] sends_for(input logic [3:0] c);
    case (c)
      4'd0, 4'd1: sends_for = 3'd0;
      4'd2:       sends_for = 3'd1;
      4'd3:       sends_for = 3'd2;
      default:    sends_for = 3'd4;
    endcase
  endfunction

  // Free-running garbage hole column, 0..9.
  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst)                 hole_r <= 4'd0;
    else if (hole_r == 4'd9) hole_r <= 4'd0;
    else                     hole_r <= hole_r + 4'd1;
  end

  // Per-row full flags of the working table.
  always_comb begin
    for (int r = 0; r < 10; r++) full_s[r] = &work_r[r*10 +: 10];
  end

  // Next-state and working-table update.
  always_comb begin
    state_s    = state_r;
    work_s     = work_r;
    row_ptr_s  = row_ptr_r;
    clr_cnt_s  = clr_cnt_r;
    send_cnt_s = send_cnt_r;
    send_ph_s  = send_ph_r;
    line_clr_s = 1'b0;
    pend_dec_s = 1'b0;
    overflow_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          work_s    = table_in;
          row_ptr_s = 4'd9;
          clr_cnt_s = 4'd0;
          state_s   = SCAN;
        end else begin
          state_s   = IDLE;
        end
      end
      SCAN: begin
        if (full_s[row_ptr_r]) begin
          work_s     = collapse_rows(work_r, row_ptr_r);
          clr_cnt_s  = clr_cnt_r + 4'd1;
          line_clr_s = 1'b1;
        end else if (row_ptr_r == 4'd0) begin
          state_s    = GARBAGE;
        end else begin
          row_ptr_s  = row_ptr_r - 4'd1;
        end
      end
      GARBAGE: begin
        if (pending != 4'd0) begin
          // Whatever sits in row 0 is pushed off the top and lost.
          work_s     = {~(10'd1 << hole_r), work_r[99:10]};
          pend_dec_s = 1'b1;
          overflow_s = |work_r[9:0];
        end else begin
          state_s    = COMMIT;
        end
      end
      COMMIT: begin
        send_cnt_s = sends_for(clr_cnt_r);
        send_ph_s  = 1'b0;
        if (sends_for(clr_cnt_r) != 3'd0) state_s = SEND;
        else                              state_s = DONE;
      end
      SEND: begin
        if (!send_ph_r) begin
          send_ph_s  = 1'b1;
        end else begin
          send_ph_s  = 1'b0;
          send_cnt_s = send_cnt_r - 3'd1;
          if (send_cnt_r == 3'd1) state_s = DONE;
          else                    state_s = SEND;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Sequencer registers and outputs, all decoded from the next state.
  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      work_r     <= 100'd0;
      row_ptr_r  <= 4'd0;
      clr_cnt_r  <= 4'd0;
      send_cnt_r <= 3'd0;
      send_ph_r  <= 1'b0;
      busy       <= 1'b0;
      table_we   <= 1'b0;
      table_out  <= 100'd0;
      send_line  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      work_r     <= work_s;
      row_ptr_r  <= row_ptr_s;
      clr_cnt_r  <= clr_cnt_s;
      send_cnt_r <= send_cnt_s;
      send_ph_r  <= send_ph_s;
      busy       <= (state_s != IDLE);
      table_we   <= (state_s == COMMIT);
      table_out  <= (state_s == COMMIT) ? work_s : table_out;
      send_line  <= (state_s == SEND) && !send_ph_s;
      done       <= (state_s == DONE);
    end
  end

  // Garbage queue: opponent increments, insertion decrements, both together hold.
  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      pending <= 4'd0;
    end else begin
      case ({add_line, pend_dec_s})
        2'b10:   pending <= (pending == 4'd15) ? pending : pending + 4'd1;
        2'b01:   pending <= pending - 4'd1;
        default: pending <= pending;
      endcase
    end
  end

  // Cleared-row statistics and sticky overflow flag.
  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      lines_total <= 8'd0;
      game_over   <= 1'b0;
    end else begin
      if (line_clr_s && (lines_total != 8'd255)) lines_total <= lines_total + 8'd1;
      else                                        lines_total <= lines_total;
      if (overflow_s) game_over <= 1'b1;
      else            game_over <= game_over;
    end
  end

endmodule

// File: tb/tb_line_clear_scheduler.sv
// Self-checking bench for line_clear_scheduler: table-driven sequences through a
// scoreboard queue, plus hand-written garbage, overflow, queue and reset sequences.
module tb_line_clear_scheduler;

  logic        clk_40M = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [99:0] table_in = '0;
  logic        add_line = 1'b0;
  logic        busy, table_we, send_line, done, game_over;
  logic [99:0] table_out;
  logic [3:0]  pending;
  logic [7:0]  lines_total;

  line_clear_scheduler dut (
    .clk_40M(clk_40M), .rst(rst), .start(start), .table_in(table_in),
    .add_line(add_line), .busy(busy), .table_out(table_out), .table_we(table_we),
    .send_line(send_line), .done(done), .pending(pending),
    .lines_total(lines_total), .game_over(game_over)
  );

  always #12 clk_40M = ~clk_40M;

  typedef struct {
    logic [99:0] tin;
    logic [99:0] tout;
    int          k;
    int          s;
  } vec_t;

  typedef struct {
    logic [99:0] tout;
    int          we_off;
    int          s;
    int          done_off;
    int          lines;
  } exp_t;

  vec_t  vecs[6];
  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    lines_m = 0;
  logic [3:0] hole_m;

  always @(posedge clk_40M) cyc <= cyc + 1;

  // Reference hole column: counts 0..9 every cycle out of reset.
  always @(posedge clk_40M or posedge rst) begin
    if (rst) hole_m <= 4'd0;
    else     hole_m <= (hole_m == 4'd9) ? 4'd0 : hole_m + 4'd1;
  end

  function automatic logic [99:0] row_mask(input int row, input logic [9:0] bits);
    logic [99:0] v;
    v = {90'd0, bits};
    return v << (row * 10);
  endfunction

  task automatic check(input string name, input logic [99:0] act, input logic [99:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_40M);
    #1;
  endtask

  // Called just after a rising edge: that cycle is T, the start cycle.
  task automatic run_one(input logic [99:0] tin, input logic [99:0] tout,
                         input int k, input int g, input int s, input string tag);
    exp_t e, x;
    int t0, we_off, we_cnt, sends, send_bad, done_off, busy_bad;
    logic [99:0] got_tout;
    e.tout     = tout;
    e.we_off   = 12 + k + g;
    e.s        = s;
    e.done_off = 13 + k + g + 2 * s;
    lines_m    = (lines_m + k > 255) ? 255 : lines_m + k;
    e.lines    = lines_m;
    exp_q.push_back(e);
    start = 1'b1; table_in = tin; t0 = cyc;
    tick();
    start = 1'b0; table_in = '0;
    we_off = -1; we_cnt = 0; sends = 0; send_bad = 0; done_off = -1; busy_bad = 0;
    got_tout = '0;
    for (int i = 0; i < 100 && done_off < 0; i++) begin
      @(negedge clk_40M);
      if (!busy) busy_bad++;
      if (table_we) begin we_cnt++; we_off = cyc - t0; got_tout = table_out; end
      if (send_line) begin
        if (cyc - t0 != e.we_off + 1 + 2 * sends) send_bad++;
        sends++;
      end
      if (done) done_off = cyc - t0;
    end
    @(negedge clk_40M);
    x = exp_q.pop_front();
    check_int({tag, "_we_cycle"}, we_off, x.we_off);
    check_int({tag, "_we_count"}, we_cnt, 1);
    check({tag, "_table_out"}, got_tout, x.tout);
    check_int({tag, "_sends"}, sends, x.s);
    check_int({tag, "_send_spacing"}, send_bad, 0);
    check_int({tag, "_done_cycle"}, done_off, x.done_off);
    check_int({tag, "_busy_span"}, busy_bad, 0);
    check({tag, "_busy_after"}, {99'd0, busy}, 100'd0);
    check({tag, "_table_hold"}, table_out, x.tout);
    check_int({tag, "_lines_total"}, int'(lines_total), x.lines);
    tick();
  endtask

  initial begin
    logic [99:0] tout;
    int hb, t0c, done_c, we_c;

    vecs[0].tin = '0; vecs[0].tout = '0; vecs[0].k = 0; vecs[0].s = 0;
    vecs[1].tin  = row_mask(9, 10'h3FF) | row_mask(8, 10'h3FF) | row_mask(7, 10'b0000000011);
    vecs[1].tout = row_mask(9, 10'b0000000011); vecs[1].k = 2; vecs[1].s = 1;
    vecs[2].tin  = row_mask(9, 10'h3FF) | row_mask(8, 10'h3FF) | row_mask(7, 10'h3FF) | row_mask(6, 10'h3FF);
    vecs[2].tout = '0; vecs[2].k = 4; vecs[2].s = 4;
    vecs[3].tin  = row_mask(9, 10'h3FF) | row_mask(8, 10'b0000100000) | row_mask(7, 10'h3FF)
                 | row_mask(6, 10'b0000000100) | row_mask(5, 10'h3FF);
    vecs[3].tout = row_mask(9, 10'b0000100000) | row_mask(8, 10'b0000000100);
    vecs[3].k = 3; vecs[3].s = 2;
    vecs[4].tin  = row_mask(9, 10'h3FF) | row_mask(0, 10'b0000001000);
    vecs[4].tout = row_mask(1, 10'b0000001000); vecs[4].k = 1; vecs[4].s = 0;
    vecs[5].tin  = row_mask(9, 10'h3FE) | row_mask(4, 10'h155);
    vecs[5].tout = vecs[5].tin; vecs[5].k = 0; vecs[5].s = 0;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", {99'd0, busy}, 100'd0);
    check("rst_table_we", {99'd0, table_we}, 100'd0);
    check("rst_table_out", table_out, 100'd0);
    check("rst_send_line", {99'd0, send_line}, 100'd0);
    check("rst_done", {99'd0, done}, 100'd0);
    check("rst_pending", {96'd0, pending}, 100'd0);
    check("rst_lines_total", {92'd0, lines_total}, 100'd0);
    check("rst_game_over", {99'd0, game_over}, 100'd0);

    for (int i = 0; i < 6; i++)
      run_one(vecs[i].tin, vecs[i].tout, vecs[i].k, 0, vecs[i].s, $sformatf("vec%0d", i));

    // Two garbage rows with the hole sampled as 3 then 4.
    repeat (2) begin add_line = 1'b1; tick(); add_line = 1'b0; tick(); end
    check("garb_pending_q", {96'd0, pending}, 100'd2);
    for (int i = 0; i < 12 && hole_m != 4'd2; i++) tick();
    tout = row_mask(8, ~(10'd1 << 3)) | row_mask(9, ~(10'd1 << 4));
    run_one('0, tout, 0, 2, 0, "garb");
    check("garb_pending_end", {96'd0, pending}, 100'd0);
    check("garb_no_over", {99'd0, game_over}, 100'd0);

    // Row 0 occupied while one garbage row is inserted.
    add_line = 1'b1; tick(); add_line = 1'b0;
    hb = (int'(hole_m) + 11) % 10;
    run_one(row_mask(0, 10'b0000100000), row_mask(9, ~(10'd1 << hb)), 0, 1, 0, "over");
    check("over_set", {99'd0, game_over}, 100'd1);
    run_one('0, '0, 0, 0, 0, "over2");
    check("over_sticky", {99'd0, game_over}, 100'd1);

    // add_line in the same cycle as the first garbage decrement.
    add_line = 1'b1; tick(); add_line = 1'b0;
    check("coin_pending_q", {96'd0, pending}, 100'd1);
    start = 1'b1; table_in = '0; t0c = cyc; tick(); start = 1'b0;
    repeat (10) tick();
    add_line = 1'b1; tick(); add_line = 1'b0;
    check("coin_pending_net", {96'd0, pending}, 100'd1);
    done_c = -1;
    for (int i = 0; i < 40 && done_c < 0; i++) begin
      @(negedge clk_40M);
      if (done) done_c = cyc - t0c;
    end
    check_int("coin_done_cycle", done_c, 15);
    tick();
    check("coin_pending_end", {96'd0, pending}, 100'd0);

    // Saturation of the garbage queue.
    repeat (16) begin add_line = 1'b1; tick(); add_line = 1'b0; tick(); end
    check("sat_pending", {96'd0, pending}, 100'd15);

    // Reset in the middle of SCAN.
    start = 1'b1; table_in = vecs[2].tin; tick(); start = 1'b0;
    tick(); tick();
    check("mid_busy_pre", {99'd0, busy}, 100'd1);
    rst = 1'b1; #2;
    check("mid_busy", {99'd0, busy}, 100'd0);
    check("mid_table_out", table_out, 100'd0);
    check("mid_pending", {96'd0, pending}, 100'd0);
    check("mid_lines_total", {92'd0, lines_total}, 100'd0);
    check("mid_game_over", {99'd0, game_over}, 100'd0);
    check("mid_outs", {97'd0, table_we, send_line, done}, 100'd0);
    tick(); tick();
    rst = 1'b0;
    we_c = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_40M);
      if (table_we || busy) we_c++;
    end
    check_int("mid_no_we", we_c, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
